// File: rtl/dct_pkg.sv
// Shared constants, vector types and the output rescaling helper for the
// 2-D DCT datapath.
package dct_pkg;

  localparam int DCT_N            = 8;
  localparam int DCT_IN_BITWIDTH  = 20;
  localparam int DCT_SHIFT        = 0;
  localparam int DCT_OUT_BITWIDTH = DCT_IN_BITWIDTH - DCT_SHIFT;
  localparam int CALC_BITWIDTH    = 64;

  typedef logic signed [DCT_IN_BITWIDTH-1:0]  in_elem_t;
  typedef logic signed [DCT_OUT_BITWIDTH-1:0] out_elem_t;
  typedef in_elem_t  [DCT_N-1:0] row_vec_t;
  typedef out_elem_t [DCT_N-1:0] col_vec_t;

  // Round-half-up right shift followed by saturation to out_bitwidth bits;
  // the wide working width leaves headroom for the rounding bias.
  function automatic logic signed [CALC_BITWIDTH-1:0] round_shift_sat(
    input logic signed [CALC_BITWIDTH-1:0] x,
    input int                              shift,
    input int                              out_bitwidth
  );
    logic signed [CALC_BITWIDTH-1:0] v;
    logic signed [CALC_BITWIDTH-1:0] max_val;
    logic signed [CALC_BITWIDTH-1:0] min_val;
    max_val = (64'sd1 <<< (out_bitwidth - 1)) - 64'sd1;
    min_val = -(64'sd1 <<< (out_bitwidth - 1));
    if (shift == 0) begin
      v = x;
    end else begin
      v = (x + (64'sd1 <<< (shift - 1))) >>> shift;
      if (v > max_val) v = max_val;
      if (v < min_val) v = min_val;
    end
    return v;
  endfunction

endpackage

// File: rtl/dct_transpose_buffer_bank.sv
// One N x N storage bank: a whole row is written at once, a whole column is
// read combinationally.
module transpose_bank
  import dct_pkg::*;
#(
  parameter int N     = DCT_N,
  parameter int WIDTH = DCT_IN_BITWIDTH
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [$clog2(N)-1:0]   wr_row,
  input  logic [N*WIDTH-1:0]     wr_line,
  input  logic [$clog2(N)-1:0]   rd_col,
  output logic [N*WIDTH-1:0]     rd_line
);

  logic [WIDTH-1:0] mem [N][N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < N; k++) begin
        mem[wr_row][k] <= wr_line[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    rd_line = '0;
    for (int r = 0; r < N; r++) begin
      rd_line[r*WIDTH +: WIDTH] = mem[r][rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong transpose buffer between the row and column passes of the 2-D
// DCT: rows go into one bank while the other bank is read out by columns.
module dct_transpose_buffer
  import dct_pkg::*;
#(
  parameter int MATRIX_SIZE  = DCT_N,
  parameter int IN_BITWIDTH  = DCT_IN_BITWIDTH,
  parameter int SHIFT        = DCT_SHIFT,
  parameter int OUT_BITWIDTH = IN_BITWIDTH - SHIFT
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic [MATRIX_SIZE*IN_BITWIDTH-1:0]  i_line,
  input  logic                                i_valid,
  output logic                                o_ready,
  output logic [MATRIX_SIZE*OUT_BITWIDTH-1:0] o_line,
  output logic                                o_valid,
  output logic                                o_first,
  input  logic                                i_ready
);

  localparam int PTR_W = $clog2(MATRIX_SIZE);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(MATRIX_SIZE - 1);

  logic [1:0]       full;
  logic [1:0]       full_next;
  logic             wr_bank;
  logic             rd_bank;
  logic [PTR_W-1:0] wr_row;
  logic [PTR_W-1:0] rd_col;
  logic             write_fire;
  logic             read_fire;
  logic             write_last;
  logic             read_last;

  logic [MATRIX_SIZE*IN_BITWIDTH-1:0] bank_line [2];
  logic [MATRIX_SIZE*IN_BITWIDTH-1:0] sel_line;

  assign o_ready    = !full[wr_bank];
  assign o_valid    = full[rd_bank];
  assign o_first    = o_valid && (rd_col == '0);
  assign write_fire = i_valid && o_ready;
  assign read_fire  = o_valid && i_ready;
  assign write_last = write_fire && (wr_row == LAST);
  assign read_last  = read_fire && (rd_col == LAST);

  // Completing a write and a read in the same cycle always involves
  // different banks, so both flag updates can apply together.
  always_comb begin
    full_next = full;
    if (write_last) full_next[wr_bank] = 1'b1;
    if (read_last)  full_next[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row  <= '0;
      rd_col  <= '0;
    end else begin
      full <= full_next;
      if (write_fire) begin
        if (write_last) begin
          wr_row  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_row <= wr_row + PTR_W'(1);
        end
      end
      if (read_fire) begin
        if (read_last) begin
          rd_col  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_col <= rd_col + PTR_W'(1);
        end
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    transpose_bank #(
      .N     (MATRIX_SIZE),
      .WIDTH (IN_BITWIDTH)
    ) u_bank (
      .clk     (clk),
      .wr_en   (write_fire && (wr_bank == 1'(b))),
      .wr_row  (wr_row),
      .wr_line (i_line),
      .rd_col  (rd_col),
      .rd_line (bank_line[b])
    );
  end

  assign sel_line = bank_line[rd_bank];

  always_comb begin
    o_line = '0;
    for (int r = 0; r < MATRIX_SIZE; r++) begin
      o_line[r*OUT_BITWIDTH +: OUT_BITWIDTH] = OUT_BITWIDTH'(round_shift_sat(
        CALC_BITWIDTH'($signed(sel_line[r*IN_BITWIDTH +: IN_BITWIDTH])),
        SHIFT, OUT_BITWIDTH));
    end
  end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Scoreboard bench: two buffers (plain and SHIFT=3) share one row stream and
// are compared against a block-transpose model with rounding.
module tb_dct_transpose_buffer;

  localparam int N   = 8;
  localparam int IW  = 20;
  localparam int SH  = 3;
  localparam int OW3 = IW - SH;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              i_valid = 1'b0;
  logic              i_ready = 1'b0;
  logic [N*IW-1:0]   i_line = '0;
  logic [N*IW-1:0]   o_line0;
  logic [N*OW3-1:0]  o_line3;
  logic              o_ready0, o_valid0, o_first0;
  logic              o_ready3, o_valid3, o_first3;

  int checks = 0;
  int errors = 0;
  int pending = 0;
  int col = 0;
  int wr_cnt = 0;
  int rdy_mode = 1;
  logic [N*IW-1:0]  q0 [$];
  logic [N*OW3-1:0] q3 [$];
  logic signed [IW-1:0] blk [N][N];

  always #5 clk = ~clk;

  dct_transpose_buffer #(.MATRIX_SIZE(N), .IN_BITWIDTH(IW), .SHIFT(0), .OUT_BITWIDTH(IW)) dut0 (
    .clk(clk), .n_rst(n_rst), .i_line(i_line), .i_valid(i_valid), .o_ready(o_ready0),
    .o_line(o_line0), .o_valid(o_valid0), .o_first(o_first0), .i_ready(i_ready)
  );

  dct_transpose_buffer #(.MATRIX_SIZE(N), .IN_BITWIDTH(IW), .SHIFT(SH), .OUT_BITWIDTH(OW3)) dut3 (
    .clk(clk), .n_rst(n_rst), .i_line(i_line), .i_valid(i_valid), .o_ready(o_ready3),
    .o_line(o_line3), .o_valid(o_valid3), .o_first(o_first3), .i_ready(i_ready)
  );

  // Reference rescale: floor((x + 4) / 8), clamped to the 17-bit signed range.
  function automatic logic [OW3-1:0] refRound(input logic signed [IW-1:0] x);
    longint v;
    v = (longint'(x) + 4) >>> SH;
    if (v > 65535) v = 65535;
    if (v < -65536) v = -65536;
    return v[OW3-1:0];
  endfunction

  function automatic logic [N*IW-1:0] randRow();
    logic [N*IW-1:0] row;
    for (int k = 0; k < N; k++) row[k*IW +: IW] = IW'($urandom);
    return row;
  endfunction

  function automatic logic [N*IW-1:0] patternRow(input int r);
    logic [N*IW-1:0] row;
    for (int k = 0; k < N; k++) row[k*IW +: IW] = IW'(N*r + k);
    return row;
  endfunction

  task automatic checkOutput(input string name, input logic [N*IW-1:0] act,
                             input logic [N*IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model side: an accepted row joins the current block; a completed block
  // is transposed into expected columns for both DUT variants.
  task automatic recordRow(input logic [N*IW-1:0] row);
    logic [N*IW-1:0]  e0;
    logic [N*OW3-1:0] e3;
    for (int k = 0; k < N; k++) blk[wr_cnt][k] = row[k*IW +: IW];
    wr_cnt++;
    if (wr_cnt == N) begin
      for (int c = 0; c < N; c++) begin
        e0 = '0;
        e3 = '0;
        for (int r = 0; r < N; r++) begin
          e0[r*IW +: IW]   = blk[r][c];
          e3[r*OW3 +: OW3] = refRound(blk[r][c]);
        end
        q0.push_back(e0);
        q3.push_back(e3);
      end
      pending++;
      wr_cnt = 0;
    end
  endtask

  task automatic applyStimulus(input logic [N*IW-1:0] row);
    logic acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_line  = row;
      #1;
      acc = o_ready0;
      @(posedge clk);
      tries++;
      if (!acc && tries > 300) begin
        checks++;
        errors++;
        $display("[TB] FAIL row_accept actual=not_accepted required=accepted_within_300");
        break;
      end
    end
    if (acc) recordRow(row);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      i_valid = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic waitDrain(input int bound);
    int n;
    n = 0;
    while (pending > 0 && n < bound) begin
      @(negedge clk);
      i_valid = 1'b0;
      @(posedge clk);
      n++;
    end
    checks++;
    if (pending > 0) begin
      errors++;
      $display("[TB] FAIL drain actual=%0d_blocks_left required=0", pending);
    end
    idleCycles(2);
  endtask

  task automatic doReset();
    @(negedge clk);
    n_rst   = 1'b0;
    i_valid = 1'b0;
    @(posedge clk);
    q0.delete();
    q3.delete();
    pending = 0;
    col     = 0;
    wr_cnt  = 0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rdy_mode == 0)      i_ready = 1'b0;
      else if (rdy_mode == 1) i_ready = 1'b1;
      else                    i_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares handshake flags every cycle and the presented column
  // against the scoreboard head, then retires it when the column is taken.
  initial begin
    logic fire;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      checkOutput("o_valid0", o_valid0, pending > 0);
      checkOutput("o_valid3", o_valid3, pending > 0);
      checkOutput("o_ready0", o_ready0, pending < 2);
      checkOutput("o_ready3", o_ready3, pending < 2);
      checkOutput("o_first0", o_first0, (pending > 0) && (col == 0));
      checkOutput("o_first3", o_first3, (pending > 0) && (col == 0));
      if (pending > 0 && q0.size() > 0) begin
        checkOutput("o_line0", o_line0, q0[0]);
        checkOutput("o_line3", o_line3, q3[0]);
      end
      fire = (pending > 0) && i_ready && n_rst;
      @(posedge clk);
      if (fire && q0.size() > 0) begin
        void'(q0.pop_front());
        void'(q3.pop_front());
        col++;
        if (col == N) begin
          col = 0;
          pending--;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic signed [IW-1:0] rvals [6];
    logic [N*IW-1:0] row;
    rvals[0] = 20'sd12;
    rvals[1] = -20'sd12;
    rvals[2] = 20'sd4;
    rvals[3] = -20'sd5;
    rvals[4] = 20'sd524287;
    rvals[5] = -20'sd524288;

    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    idleCycles(2);

    $display("[TB] single block, streaming");
    rdy_mode = 1;
    for (int r = 0; r < N; r++) applyStimulus(patternRow(r));
    waitDrain(40);

    $display("[TB] back-to-back blocks");
    for (int b = 0; b < 3; b++)
      for (int r = 0; r < N; r++) applyStimulus(randRow());
    waitDrain(40);

    $display("[TB] backpressure with both banks full");
    rdy_mode = 0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < N; r++) applyStimulus(randRow());
    idleCycles(4);
    rdy_mode = 1;
    for (int r = 0; r < N; r++) applyStimulus(randRow());
    waitDrain(60);

    $display("[TB] random downstream stalls");
    rdy_mode = 2;
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(0, 3) == 0) idleCycles(1);
        applyStimulus(randRow());
      end
    waitDrain(400);

    $display("[TB] rounding and saturation");
    rdy_mode = 1;
    for (int r = 0; r < N; r++) begin
      row = '0;
      for (int k = 0; k < N; k++) row[k*IW +: IW] = rvals[(r*N + k) % 6];
      applyStimulus(row);
    end
    waitDrain(40);

    $display("[TB] reset mid-operation");
    rdy_mode = 0;
    for (int r = 0; r < N; r++) applyStimulus(randRow());
    for (int r = 0; r < 2; r++) applyStimulus(randRow());
    rdy_mode = 1;
    for (int r = 0; r < 3; r++) applyStimulus(randRow());
    doReset();
    for (int r = 0; r < N; r++) applyStimulus(patternRow(r));
    waitDrain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
